// File: rtl/fft_job_sched.sv
// Job scheduler for a shared FFT core: round-robin arbitration between two requesters,
// optional config push, input trigger, completion wait and timeout abort.
module fft_job_sched #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int NFFT           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [8:0] req_cfg0,
    input  logic [8:0] req_cfg1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       busy,
    output logic [8:0] cfg_data,
    output logic       cfg_commit,
    input  logic       cfg_ack,
    output logic       in_trig,
    input  logic       out_last
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        START  = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    if (NFFT < 2 || (NFFT & (NFFT - 1)) != 0) begin : g_nfft_check
        $error("fft_job_sched: NFFT must be a power of two >= 2");
    end

    state_t      r_state;
    logic        r_owner;
    logic        r_rr_ptr;
    logic        r_last_cfg_valid;
    logic [8:0]  r_last_cfg;
    logic [31:0] r_cnt;
    logic [1:0]  r_gnt;
    logic [1:0]  r_done;
    logic [1:0]  r_err;
    logic        r_busy;
    logic [8:0]  r_cfg_data;
    logic        r_cfg_commit;
    logic        r_in_trig;

    logic        w_winner;
    logic [8:0]  w_win_cfg;
    logic        w_skip;
    logic        w_timeout;
    logic [1:0]  w_owner_1h;

    // r_rr_ptr names the requester that currently holds priority.
    always_comb begin
        w_winner   = req[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
        w_win_cfg  = w_winner ? req_cfg1 : req_cfg0;
        w_skip     = r_last_cfg_valid && (w_win_cfg == r_last_cfg);
        w_timeout  = (r_cnt == TO_LAST);
        w_owner_1h = {r_owner, ~r_owner};
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_owner          <= 1'b0;
            r_rr_ptr         <= 1'b0;
            r_last_cfg_valid <= 1'b0;
            r_last_cfg       <= 9'd0;
            r_cnt            <= 32'd0;
            r_gnt            <= 2'b00;
            r_done           <= 2'b00;
            r_err            <= 2'b00;
            r_busy           <= 1'b0;
            r_cfg_data       <= 9'd0;
            r_cfg_commit     <= 1'b0;
            r_in_trig        <= 1'b0;
        end else begin
            r_done       <= 2'b00;
            r_err        <= 2'b00;
            r_cfg_commit <= 1'b0;
            r_in_trig    <= 1'b0;
            if (r_state != IDLE) begin
                r_cnt <= r_cnt + 32'd1;
            end
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_owner    <= w_winner;
                        r_gnt      <= {w_winner, ~w_winner};
                        r_cfg_data <= w_win_cfg;
                        r_cnt      <= 32'd0;
                        r_busy     <= 1'b1;
                        if (w_skip) begin
                            r_state   <= START;
                            r_in_trig <= 1'b1;
                        end else begin
                            r_state      <= CONFIG;
                            r_cfg_commit <= 1'b1;
                        end
                    end
                end
                CONFIG: begin
                    if (cfg_ack) begin
                        r_last_cfg       <= r_cfg_data;
                        r_last_cfg_valid <= 1'b1;
                        r_state          <= START;
                        r_in_trig        <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= ERR;
                        r_err   <= w_owner_1h;
                    end
                end
                START: begin
                    r_state <= STREAM;
                end
                STREAM: begin
                    // Completion takes precedence over a coincident timeout.
                    if (out_last) begin
                        r_state <= DONE;
                        r_done  <= w_owner_1h;
                    end else if (w_timeout) begin
                        r_state <= ERR;
                        r_err   <= w_owner_1h;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_gnt    <= 2'b00;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= ~r_owner;
                end
                ERR: begin
                    r_state          <= IDLE;
                    r_gnt            <= 2'b00;
                    r_busy           <= 1'b0;
                    r_rr_ptr         <= ~r_owner;
                    r_last_cfg_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = r_busy;
    assign cfg_data   = r_cfg_data;
    assign cfg_commit = r_cfg_commit;
    assign in_trig    = r_in_trig;

endmodule
